// File: rtl/alu_arbiter_seq_if.sv
// Bundle of requester, response and ALU-side signals for alu_arbiter_seq.
// The slave modport is the arbiter's view; the master modport is the view
// of whatever drives the requests and hosts the ALU.
`timescale 1ns/1ps
interface alu_arbiter_seq_if;
   // request channels
   logic        req0_valid;
   logic        req1_valid;
   logic        req0_ready;
   logic        req1_ready;
   logic [15:0] req0_a;
   logic [15:0] req0_b;
   logic [15:0] req1_a;
   logic [15:0] req1_b;
   logic [2:0]  req0_op;
   logic [2:0]  req1_op;
   // response channels (data shared by both)
   logic        resp0_valid;
   logic        resp1_valid;
   logic        resp0_ready;
   logic        resp1_ready;
   logic [15:0] resp_q;
   logic        resp_cout;
   logic        resp_zero;
   // ALU datapath hookup
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [2:0]  alu_op;
   logic [15:0] alu_q;
   logic        alu_cout;
   // status
   logic        busy;

   modport slave (
      input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
             req0_op, req1_op, resp0_ready, resp1_ready, alu_q, alu_cout,
      output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_q,
             resp_cout, resp_zero, alu_a, alu_b, alu_op, busy
   );

   modport master (
      output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
             req0_op, req1_op, resp0_ready, resp1_ready, alu_q, alu_cout,
      input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_q,
             resp_cout, resp_zero, alu_a, alu_b, alu_op, busy
   );
endinterface

// File: rtl/alu_arbiter_seq.sv
// Two-requester round-robin arbiter and issue sequencer for a combinational
// ripple ALU: registers the granted operands, waits SETTLE cycles for the
// carry chain, captures the result and hands it back to the owner.
`timescale 1ns/1ps
module alu_arbiter_seq #(
   parameter int unsigned SETTLE = 4   // legal 1..15
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_arbiter_seq_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // Counter preload: capture happens on the edge where cnt reaches zero,
   // so SETTLE-1 gives exactly SETTLE edges after the accept edge.
   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        owner_q;
   logic        last_grant_q;
   logic [15:0] alu_a_q;
   logic [15:0] alu_b_q;
   logic [2:0]  alu_op_q;
   logic [15:0] res_val_q;
   logic        res_cout_q;
   logic        res_zero_q;
   logic        resp0_valid_q;
   logic        resp1_valid_q;
   logic        busy_q;

   logic        grant_d;
   logic        idle;
   logic        accept;
   logic        take;
   logic [15:0] sel_a_d;
   logic [15:0] sel_b_d;
   logic [2:0]  sel_op_d;

   // Round-robin grant: a lone valid wins outright, a tie goes to the
   // requester that did not win last time.
   always_comb begin
      grant_d = ~last_grant_q;
      if (bus.req0_valid && !bus.req1_valid) begin
         grant_d = 1'b0;
      end else if (bus.req1_valid && !bus.req0_valid) begin
         grant_d = 1'b1;
      end
   end

   assign idle           = (state_q == ST_IDLE);
   assign bus.req0_ready = idle && !grant_d;
   assign bus.req1_ready = idle &&  grant_d;
   assign accept         = idle && (grant_d ? bus.req1_valid : bus.req0_valid);
   assign take           = owner_q ? bus.resp1_ready : bus.resp0_ready;

   // Operand/opcode mux for the granted requester.
   always_comb begin
      sel_a_d  = bus.req0_a;
      sel_b_d  = bus.req0_b;
      sel_op_d = bus.req0_op;
      if (grant_d) begin
         sel_a_d  = bus.req1_a;
         sel_b_d  = bus.req1_b;
         sel_op_d = bus.req1_op;
      end
   end

   // Sequencer FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 4'd0;
         owner_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         alu_a_q       <= 16'd0;
         alu_b_q       <= 16'd0;
         alu_op_q      <= 3'd0;
         res_val_q     <= 16'd0;
         res_cout_q    <= 1'b0;
         res_zero_q    <= 1'b0;
         resp0_valid_q <= 1'b0;
         resp1_valid_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  alu_a_q      <= sel_a_d;
                  alu_b_q      <= sel_b_d;
                  alu_op_q     <= sel_op_d;
                  owner_q      <= grant_d;
                  last_grant_q <= grant_d;
                  cnt_q        <= CNT_INIT;
                  busy_q       <= 1'b1;
                  state_q      <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  res_val_q     <= bus.alu_q;
                  res_cout_q    <= bus.alu_cout;
                  res_zero_q    <= (bus.alu_q == 16'd0);
                  resp0_valid_q <= ~owner_q;
                  resp1_valid_q <= owner_q;
                  state_q       <= ST_RESP;
               end
            end
            ST_RESP: begin
               // only the owner's ready matters; the other channel is ignored
               if (take) begin
                  resp0_valid_q <= 1'b0;
                  resp1_valid_q <= 1'b0;
                  busy_q        <= 1'b0;
                  state_q       <= ST_IDLE;
               end
            end
            default: begin
               resp0_valid_q <= 1'b0;
               resp1_valid_q <= 1'b0;
               busy_q        <= 1'b0;
               state_q       <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.alu_a       = alu_a_q;
   assign bus.alu_b       = alu_b_q;
   assign bus.alu_op      = alu_op_q;
   assign bus.resp_q      = res_val_q;
   assign bus.resp_cout   = res_cout_q;
   assign bus.resp_zero   = res_zero_q;
   assign bus.resp0_valid = resp0_valid_q;
   assign bus.resp1_valid = resp1_valid_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Bench for alu_arbiter_seq: directed vectors plus randomized traffic,
// checked every cycle against a transaction-level timing/result model.
`timescale 1ns/1ps
module tb_alu_arbiter_seq;

   localparam int SET = 4;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  op;
      bit          pinq;
      bit          pinc;
      logic [15:0] q;
      logic        cout;
   } op_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   alu_arbiter_seq_if bus ();
   alu_arbiter_seq_if bus1 ();

   alu_arbiter_seq #(.SETTLE(SET)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   alu_arbiter_seq #(.SETTLE(1))   u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   // Behavioural ALU: b optionally inverted with carry-in 1, then AND/OR/SUM/SLT.
   function automatic logic [16:0] ref_alu(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] op);
      logic [15:0] bb;
      logic [16:0] sum;
      bb  = op[2] ? ~b : b;
      sum = {1'b0, a} + {1'b0, bb} + {16'd0, op[2]};
      case (op[1:0])
         2'b00:   return {sum[16], a & bb};
         2'b01:   return {sum[16], a | bb};
         2'b10:   return sum;
         default: return {sum[16], 15'd0, sum[15]};
      endcase
   endfunction

   logic [16:0] alu_res;
   logic [16:0] alu_res1;
   assign alu_res       = ref_alu(bus.alu_a, bus.alu_b, bus.alu_op);
   assign bus.alu_q     = alu_res[15:0];
   assign bus.alu_cout  = alu_res[16];
   assign alu_res1      = ref_alu(bus1.alu_a, bus1.alu_b, bus1.alu_op);
   assign bus1.alu_q    = alu_res1[15:0];
   assign bus1.alu_cout = alu_res1[16];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // stimulus state
   op_t dq0[$];
   op_t dq1[$];
   op_t pend[2];
   bit  pend_v[2];
   bit  acc_flag[2];
   bit  rr[2];
   bit  rand_mode = 0;
   bit  rand_rr = 0;

   // reference model state
   bit  out_m = 0;
   int  owner_m = 0;
   int  acc_m = 0;
   int  last_m = 1;
   op_t cur_m;
   int  acc_own[$];
   int  acc_cyc[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic op_t mk(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                              input bit pinq, input bit pinc, input logic [15:0] q,
                              input logic cout);
      op_t o;
      o.a = a; o.b = b; o.op = op; o.pinq = pinq; o.pinc = pinc; o.q = q; o.cout = cout;
      return o;
   endfunction

   function automatic op_t rand_op();
      logic [15:0] a;
      logic [15:0] b;
      a = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      return mk(a, b, 3'($urandom_range(0, 7)), 0, 0, 16'd0, 1'b0);
   endfunction

   // Per-cycle model step, run at the falling edge.
   task automatic monitor();
      bit v0, v1;
      int w;
      bit resp_ph;
      logic [16:0] r;
      v0 = bus.req0_valid;
      v1 = bus.req1_valid;
      check_val("busy", 32'(bus.busy), 32'(out_m));
      if (out_m) begin
         check_val("req0_ready_busy", 32'(bus.req0_ready), 32'd0);
         check_val("req1_ready_busy", 32'(bus.req1_ready), 32'd0);
         check_val("alu_a", 32'(bus.alu_a), 32'(cur_m.a));
         check_val("alu_b", 32'(bus.alu_b), 32'(cur_m.b));
         check_val("alu_op", 32'(bus.alu_op), 32'(cur_m.op));
         resp_ph = (cyc >= acc_m + 1 + SET);
         check_val("resp0_valid", 32'(bus.resp0_valid), 32'(resp_ph && owner_m == 0));
         check_val("resp1_valid", 32'(bus.resp1_valid), 32'(resp_ph && owner_m == 1));
         if (resp_ph) begin
            r = ref_alu(cur_m.a, cur_m.b, cur_m.op);
            check_val("resp_q", 32'(bus.resp_q), 32'(r[15:0]));
            check_val("resp_cout", 32'(bus.resp_cout), 32'(r[16]));
            check_val("resp_zero", 32'(bus.resp_zero), 32'(r[15:0] == 16'd0));
            if (cur_m.pinq) check_val("spec_q", 32'(bus.resp_q), 32'(cur_m.q));
            if (cur_m.pinc) check_val("spec_cout", 32'(bus.resp_cout), 32'(cur_m.cout));
            if ((owner_m == 0 && bus.resp0_ready) || (owner_m == 1 && bus.resp1_ready)) begin
               $display("resp req%0d q=%0d cout=%0b zero=%0b cyc=%0d", owner_m, bus.resp_q,
                        bus.resp_cout, bus.resp_zero, cyc);
               out_m = 0;
            end
         end
      end else begin
         check_val("resp0_valid_idle", 32'(bus.resp0_valid), 32'd0);
         check_val("resp1_valid_idle", 32'(bus.resp1_valid), 32'd0);
         if (v0 || v1) begin
            w = (v0 && v1) ? 1 - last_m : (v0 ? 0 : 1);
            if (v0) check_val("req0_ready", 32'(bus.req0_ready), 32'(w == 0));
            if (v1) check_val("req1_ready", 32'(bus.req1_ready), 32'(w == 1));
            out_m = 1; owner_m = w; acc_m = cyc; cur_m = pend[w]; last_m = w;
            acc_flag[w] = 1;
            acc_own.push_back(w);
            acc_cyc.push_back(cyc);
            $display("accept req%0d a=%0d b=%0d op=%b cyc=%0d", w, cur_m.a, cur_m.b, cur_m.op, cyc);
         end
      end
   endtask

   task automatic refill(input int n);
      if (n == 0 && dq0.size() > 0) begin
         pend[0] = dq0.pop_front(); pend_v[0] = 1;
      end else if (n == 1 && dq1.size() > 0) begin
         pend[1] = dq1.pop_front(); pend_v[1] = 1;
      end else if (rand_mode && $urandom_range(0, 2) == 0) begin
         pend[n] = rand_op(); pend_v[n] = 1;
      end
   endtask

   // Requester/response-side driving, run just after the rising edge.
   task automatic drive();
      bit vis[2];
      for (int n = 0; n < 2; n++) begin
         if (acc_flag[n]) begin
            pend_v[n] = 0; acc_flag[n] = 0;
         end
         if (!pend_v[n]) refill(n);
         vis[n] = pend_v[n] && (!rand_mode || $urandom_range(0, 3) != 0);
         if (rand_rr) rr[n] = 1'($urandom_range(0, 1));
      end
      bus.req0_valid = vis[0]; bus.req0_a = pend[0].a; bus.req0_b = pend[0].b; bus.req0_op = pend[0].op;
      bus.req1_valid = vis[1]; bus.req1_a = pend[1].a; bus.req1_b = pend[1].b; bus.req1_op = pend[1].op;
      bus.resp0_ready = rr[0];
      bus.resp1_ready = rr[1];
   endtask

   task automatic run_cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         monitor();
         @(posedge clk);
         #1;
         drive();
      end
   endtask

   task automatic run_until_idle(input string tag, input int max);
      int k;
      k = 0;
      while ((out_m || pend_v[0] || pend_v[1] || dq0.size() > 0 || dq1.size() > 0) && k < max) begin
         run_cycles(1);
         k++;
      end
      check_val({tag, "_timeout"}, 32'(k >= max), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      bus.req0_valid = 0; bus.req1_valid = 0;
      bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
      bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
      bus.resp0_ready = 1; bus.resp1_ready = 1;
      bus1.req0_valid = 0; bus1.req1_valid = 0;
      bus1.req0_a = 0; bus1.req0_b = 0; bus1.req0_op = 0;
      bus1.req1_a = 0; bus1.req1_b = 0; bus1.req1_op = 0;
      bus1.resp0_ready = 1; bus1.resp1_ready = 1;
      rr[0] = 1; rr[1] = 1;
      pend_v[0] = 0; pend_v[1] = 0; acc_flag[0] = 0; acc_flag[1] = 0;

      // asynchronous reset, checked before any clock edge
      #2 rst_n = 0;
      #1;
      check_val("rst_busy", 32'(bus.busy), 32'd0);
      check_val("rst_resp0_valid", 32'(bus.resp0_valid), 32'd0);
      check_val("rst_resp1_valid", 32'(bus.resp1_valid), 32'd0);
      check_val("rst_alu_a", 32'(bus.alu_a), 32'd0);
      check_val("rst_alu_b", 32'(bus.alu_b), 32'd0);
      check_val("rst_alu_op", 32'(bus.alu_op), 32'd0);
      check_val("rst_resp_q", 32'(bus.resp_q), 32'd0);
      check_val("rst_resp_cout", 32'(bus.resp_cout), 32'd0);
      check_val("rst_resp_zero", 32'(bus.resp_zero), 32'd0);
      check_val("rst1_busy", 32'(bus1.busy), 32'd0);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;

      // round-robin with both requesters valid from reset, ready tied high
      dq0.push_back(mk(16'd10, 16'd20, 3'b010, 1, 1, 16'd30, 1'b0));
      dq0.push_back(mk(16'd7, 16'd7, 3'b110, 1, 1, 16'd0, 1'b1));
      dq1.push_back(mk(16'd100, 16'd1, 3'b010, 1, 1, 16'd101, 1'b0));
      dq1.push_back(mk(16'hF0F0, 16'h0FF0, 3'b000, 1, 0, 16'h00F0, 1'b0));
      drive();
      run_until_idle("rr", 100);
      check_val("rr_count", 32'(acc_own.size()), 32'd4);
      for (int i = 0; i < acc_own.size() && i < 4; i++) begin
         check_val("rr_owner", 32'(acc_own[i]), 32'(i % 2));
         if (i > 0) check_val("rr_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(SET + 2));
      end
      acc_own.delete(); acc_cyc.delete();

      // single add, subtract/carry, SLT and logic
      dq0.push_back(mk(16'd2, 16'd3, 3'b010, 1, 1, 16'd5, 1'b0));
      dq1.push_back(mk(16'd60000, 16'd50000, 3'b110, 1, 1, 16'd10000, 1'b1));
      dq1.push_back(mk(16'd3, 16'd2, 3'b110, 1, 1, 16'd1, 1'b1));
      dq1.push_back(mk(16'd3, 16'd3, 3'b110, 1, 1, 16'd0, 1'b1));
      dq0.push_back(mk(16'd2, 16'd3, 3'b111, 1, 1, 16'd1, 1'b0));
      dq0.push_back(mk(16'd168, 16'd765, 3'b000, 1, 0, 16'd168, 1'b0));
      dq0.push_back(mk(16'd168, 16'd765, 3'b001, 1, 0, 16'd765, 1'b0));
      run_until_idle("directed", 200);

      // backpressure on requester 0 while requester 1 waits
      rr[0] = 0;
      dq0.push_back(mk(16'd1000, 16'd234, 3'b010, 1, 1, 16'd1234, 1'b0));
      k = 0;
      while (!(out_m && cyc >= acc_m + 1 + SET) && k < 50) begin
         run_cycles(1);
         k++;
      end
      check_val("bp_reach_resp", 32'(k < 50), 32'd1);
      dq1.push_back(mk(16'd5, 16'd9, 3'b001, 1, 0, 16'd13, 1'b0));
      run_cycles(10);
      rr[0] = 1;
      bus.resp0_ready = 1;
      run_until_idle("bp", 100);
      acc_own.delete(); acc_cyc.delete();

      // reset two cycles after accept aborts the op
      dq0.push_back(mk(16'd11, 16'd22, 3'b010, 0, 0, 16'd0, 1'b0));
      run_cycles(4);
      check_val("pre_rst_busy", 32'(bus.busy), 32'd1);
      #2 rst_n = 0;
      #1;
      check_val("mid_rst_busy", 32'(bus.busy), 32'd0);
      check_val("mid_rst_alu_a", 32'(bus.alu_a), 32'd0);
      check_val("mid_rst_alu_b", 32'(bus.alu_b), 32'd0);
      check_val("mid_rst_alu_op", 32'(bus.alu_op), 32'd0);
      check_val("mid_rst_resp0_valid", 32'(bus.resp0_valid), 32'd0);
      check_val("mid_rst_resp_q", 32'(bus.resp_q), 32'd0);
      out_m = 0; last_m = 1;
      pend_v[0] = 0; pend_v[1] = 0; acc_flag[0] = 0; acc_flag[1] = 0;
      bus.req0_valid = 0; bus.req1_valid = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;
      run_cycles(3);
      dq0.push_back(mk(16'd40, 16'd2, 3'b010, 1, 1, 16'd42, 1'b0));
      dq1.push_back(mk(16'd9, 16'd4, 3'b110, 1, 1, 16'd5, 1'b1));
      run_until_idle("post_rst", 100);
      check_val("post_rst_first_grant", 32'(acc_own.size() > 0 ? acc_own[0] : 9), 32'd0);

      // SETTLE=1 instance: capture on the first edge after accept
      bus1.req0_valid = 1; bus1.req0_a = 16'd7; bus1.req0_b = 16'd9; bus1.req0_op = 3'b010;
      #1;
      check_val("s1_ready", 32'(bus1.req0_ready), 32'd1);
      @(posedge clk);
      #1;
      bus1.req0_valid = 0;
      check_val("s1_busy", 32'(bus1.busy), 32'd1);
      check_val("s1_alu_a", 32'(bus1.alu_a), 32'd7);
      check_val("s1_resp0_early", 32'(bus1.resp0_valid), 32'd0);
      @(posedge clk);
      #1;
      check_val("s1_resp0_valid", 32'(bus1.resp0_valid), 32'd1);
      check_val("s1_resp1_valid", 32'(bus1.resp1_valid), 32'd0);
      check_val("s1_resp_q", 32'(bus1.resp_q), 32'd16);
      @(posedge clk);
      #1;
      check_val("s1_idle", 32'(bus1.busy), 32'd0);

      // randomized traffic with random backpressure and valid drops
      rand_mode = 1; rand_rr = 1;
      run_cycles(600);
      rand_mode = 0; rand_rr = 0;
      rr[0] = 1; rr[1] = 1;
      bus.resp0_ready = 1; bus.resp1_ready = 1;
      run_until_idle("drain", 200);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
